// File: rtl/cu_pkg.sv
// cu_pkg: shared FSM state encoding, register-file indices and ALU opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// The controller and the DataPath ALU both decode aluOp from these constants.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_ONE  = 4'd1,
    S_CLR_SUM   = 4'd2,
    S_CLR_LIM   = 4'd3,
    S_INIT_I    = 4'd4,
    S_BUILD_LIM = 4'd5,
    S_CMP       = 4'd6,
    S_ADD       = 4'd7,
    S_INC       = 4'd8,
    S_DONE      = 4'd9
  } cu_state_t;

  // Register roles: R1 = running sum, R2 = loop index i, R3 = constant 1, R4 = limit.
  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

endpackage

// File: rtl/cu_datapath.sv
// DataPath: 8x8 register file (R0 reads 0), ALU, write-source mux and output register.
// Latency: register writes and outPort loads take effect on the next rising edge.
// Backpressure: none; controlled entirely by control_unit.
// Ports: clk, reset (async, active-low, clears outPort only), control inputs from control_unit;
//        iLe10 (rData1 > alu_out) and outPort out.
module DataPath
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       RFSrcMuxSel,
  input  logic [2:0] aluOp,
  input  logic [2:0] readAddr1,
  input  logic [2:0] readAddr2,
  input  logic [2:0] writeAddr,
  input  logic       writeEn,
  input  logic       outBuf,
  output logic       iLe10,
  output logic [7:0] outPort
);

  logic [7:0] r_rf [8];
  logic [7:0] w_rdata1;
  logic [7:0] w_rdata2;
  logic [7:0] w_alu_out;
  logic [7:0] w_wdata;

  assign w_rdata1 = (readAddr1 == R0) ? 8'd0 : r_rf[readAddr1];
  assign w_rdata2 = (readAddr2 == R0) ? 8'd0 : r_rf[readAddr2];

  always_comb begin
    w_alu_out = 8'd0;
    case (aluOp)
      ALU_ADD: w_alu_out = w_rdata1 + w_rdata2;
      ALU_SUB: w_alu_out = w_rdata1 - w_rdata2;
      ALU_AND: w_alu_out = w_rdata1 & w_rdata2;
      ALU_OR:  w_alu_out = w_rdata1 | w_rdata2;
      ALU_XOR: w_alu_out = w_rdata1 ^ w_rdata2;
      ALU_NOT: w_alu_out = ~w_rdata1;
      default: w_alu_out = 8'd0;
    endcase
  end

  assign iLe10   = (w_rdata1 > w_alu_out);
  assign w_wdata = RFSrcMuxSel ? 8'd1 : w_alu_out;

  // Register file keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (writeEn && (writeAddr != R0)) begin
      r_rf[writeAddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outPort <= 8'd0;
    end else if (outBuf) begin
      outPort <= w_alu_out;
    end
  end

endmodule

// File: rtl/cu_system.sv
// cu_system: wrapper connecting control_unit to DataPath.
// Latency: as control_unit; outPort updates the edge after each ADD state.
// Backpressure: none.
// Ports: clk, reset (async, active-low), start in; busy, done, outBuf, outPort out.
// Option: CONTROL_UNIT_ABORT_EN adds input abort, passed straight to control_unit.
module cu_system #(
  parameter int LIMIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef CONTROL_UNIT_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       outBuf,
  output logic [7:0] outPort
);

  logic       w_ile10;
  logic       w_rf_src;
  logic [2:0] w_alu_op;
  logic [2:0] w_ra1;
  logic [2:0] w_ra2;
  logic [2:0] w_wa;
  logic       w_we;

  control_unit #(.LIMIT(LIMIT)) u_cu (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef CONTROL_UNIT_ABORT_EN
    .abort       (abort),
`endif
    .iLe10       (w_ile10),
    .RFSrcMuxSel (w_rf_src),
    .aluOp       (w_alu_op),
    .readAddr1   (w_ra1),
    .readAddr2   (w_ra2),
    .writeAddr   (w_wa),
    .writeEn     (w_we),
    .outBuf      (outBuf),
    .busy        (busy),
    .done        (done)
  );

  DataPath u_dp (
    .clk         (clk),
    .reset       (reset),
    .RFSrcMuxSel (w_rf_src),
    .aluOp       (w_alu_op),
    .readAddr1   (w_ra1),
    .readAddr2   (w_ra2),
    .writeAddr   (w_wa),
    .writeEn     (w_we),
    .outBuf      (outBuf),
    .iLe10       (w_ile10),
    .outPort     (outPort)
  );

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM that drives DataPath to compute sum = 1+2+...+LIMIT.
// Latency: DONE is entered 4 + LIMIT + 3*LIMIT + 1 edges after the edge accepting start.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
// Ports: clk, reset (async, active-low), start, iLe10 (rData1 > alu_out) in;
//        RFSrcMuxSel, aluOp, readAddr1, readAddr2, writeAddr, writeEn, outBuf, busy, done out.
// Option: CONTROL_UNIT_ABORT_EN adds input abort, which returns any busy state to IDLE.
module control_unit
  import cu_pkg::*;
#(
  parameter int LIMIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef CONTROL_UNIT_ABORT_EN
  input  logic       abort,
`endif
  input  logic       iLe10,
  output logic       RFSrcMuxSel,
  output logic [2:0] aluOp,
  output logic [2:0] readAddr1,
  output logic [2:0] readAddr2,
  output logic [2:0] writeAddr,
  output logic       writeEn,
  output logic       outBuf,
  output logic       busy,
  output logic       done
);

  // BUILD_LIM runs while r_lim_cnt counts 0..LIMIT-1.
  localparam logic [4:0] LIM_LAST = 5'(LIMIT - 1);

  cu_state_t  r_state;
  cu_state_t  w_next_state;
  logic [4:0] r_lim_cnt;
  logic       w_lim_clr;
  logic       w_lim_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lim_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_lim_clr) begin
        r_lim_cnt <= '0;
      end else if (w_lim_inc) begin
        r_lim_cnt <= r_lim_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    RFSrcMuxSel  = 1'b0;
    aluOp        = ALU_ADD;
    readAddr1    = R0;
    readAddr2    = R0;
    writeAddr    = R0;
    writeEn      = 1'b0;
    outBuf       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    w_lim_clr    = 1'b0;
    w_lim_inc    = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = S_LOAD_ONE;
        end
      end
      S_LOAD_ONE: begin
        RFSrcMuxSel  = 1'b1;
        writeAddr    = R3;
        writeEn      = 1'b1;
        w_next_state = S_CLR_SUM;
      end
      S_CLR_SUM: begin
        writeAddr    = R1;
        writeEn      = 1'b1;
        w_next_state = S_CLR_LIM;
      end
      S_CLR_LIM: begin
        writeAddr    = R4;
        writeEn      = 1'b1;
        w_lim_clr    = 1'b1;
        w_next_state = S_INIT_I;
      end
      S_INIT_I: begin
        readAddr1    = R3;
        writeAddr    = R2;
        writeEn      = 1'b1;
        w_next_state = S_BUILD_LIM;
      end
      S_BUILD_LIM: begin
        readAddr1 = R4;
        readAddr2 = R3;
        writeAddr = R4;
        writeEn   = 1'b1;
        w_lim_inc = 1'b1;
        if (r_lim_cnt == LIM_LAST) begin
          w_next_state = S_CMP;
        end
      end
      S_CMP: begin
        // limit - i wraps to 255 once i passes limit, which drops iLe10.
        readAddr1    = R4;
        readAddr2    = R2;
        aluOp        = ALU_SUB;
        w_next_state = iLe10 ? S_ADD : S_DONE;
      end
      S_ADD: begin
        readAddr1    = R1;
        readAddr2    = R2;
        writeAddr    = R1;
        writeEn      = 1'b1;
        outBuf       = 1'b1;
        w_next_state = S_INC;
      end
      S_INC: begin
        readAddr1    = R2;
        readAddr2    = R3;
        writeAddr    = R2;
        writeEn      = 1'b1;
        w_next_state = S_CMP;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

`ifdef CONTROL_UNIT_ABORT_EN
    // Abort overrides the state's actions so nothing is written or reported.
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      writeEn      = 1'b0;
      outBuf       = 1'b0;
      done         = 1'b0;
      w_lim_inc    = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit + DataPath (LIMIT=10) and cu_system (LIMIT=1).
// Latency: expected outPort values and done cycles are queued at start acceptance.
// Backpressure: n/a; monitors pop on outBuf and done.
module tb_control_unit;

  typedef struct packed {
    int         cyc;
    logic [7:0] sum;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // System A: control_unit + DataPath, LIMIT = 10.
  logic       a_start;
  logic       a_iLe10, a_rf_src, a_writeEn, a_outBuf, a_busy, a_done;
  logic [2:0] a_aluOp, a_ra1, a_ra2, a_wa;
  logic [7:0] a_outPort;
`ifdef CONTROL_UNIT_ABORT_EN
  logic       a_abort;
  logic       b_abort;
`endif

  control_unit #(.LIMIT(10)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (a_start),
`ifdef CONTROL_UNIT_ABORT_EN
    .abort       (a_abort),
`endif
    .iLe10       (a_iLe10),
    .RFSrcMuxSel (a_rf_src),
    .aluOp       (a_aluOp),
    .readAddr1   (a_ra1),
    .readAddr2   (a_ra2),
    .writeAddr   (a_wa),
    .writeEn     (a_writeEn),
    .outBuf      (a_outBuf),
    .busy        (a_busy),
    .done        (a_done)
  );

  DataPath u_dp_a (
    .clk         (clk),
    .reset       (reset),
    .RFSrcMuxSel (a_rf_src),
    .aluOp       (a_aluOp),
    .readAddr1   (a_ra1),
    .readAddr2   (a_ra2),
    .writeAddr   (a_wa),
    .writeEn     (a_writeEn),
    .outBuf      (a_outBuf),
    .iLe10       (a_iLe10),
    .outPort     (a_outPort)
  );

  // System B: wrapped, LIMIT = 1.
  logic       b_start;
  logic       b_busy, b_done, b_outBuf;
  logic [7:0] b_outPort;

  cu_system #(.LIMIT(1)) u_sys_b (
    .clk     (clk),
    .reset   (reset),
    .start   (b_start),
`ifdef CONTROL_UNIT_ABORT_EN
    .abort   (b_abort),
`endif
    .busy    (b_busy),
    .done    (b_done),
    .outBuf  (b_outBuf),
    .outPort (b_outPort)
  );

  logic [7:0] exp_seq10 [10] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45, 8'd55};

  logic [7:0] sum_a_q [$];
  logic [7:0] sum_b_q [$];
  done_t      done_a_q [$];
  done_t      done_b_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic push_run_a(input int k);
    done_t d;
    for (int i = 0; i < 10; i++) sum_a_q.push_back(exp_seq10[i]);
    d.cyc = k + 45;
    d.sum = 8'd55;
    done_a_q.push_back(d);
  endtask

  // Called just after a negedge; leaves at the negedge following the accepting edge.
  task automatic start_a(output int k);
    check("a_idle_before_start", int'(a_busy), 0);
    a_start = 1'b1;
    k = cyc + 1;
    push_run_a(k);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor A: outPort is compared one negedge after outBuf was seen high.
  initial begin
    logic  pend;
    done_t d;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && reset) begin
        if (sum_a_q.size() == 0) flag("a_unexpected_outbuf");
        else check("a_outPort", int'(a_outPort), int'(sum_a_q.pop_front()));
      end
      pend = a_outBuf;
      if (a_done) begin
        if (done_a_q.size() == 0) flag("a_unexpected_done");
        else begin
          d = done_a_q.pop_front();
          check("a_done_cycle", cyc, d.cyc);
          check("a_done_sum", int'(a_outPort), int'(d.sum));
        end
      end
    end
  end

  // Monitor B.
  initial begin
    logic  pend;
    done_t d;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && reset) begin
        if (sum_b_q.size() == 0) flag("b_unexpected_outbuf");
        else check("b_outPort", int'(b_outPort), int'(sum_b_q.pop_front()));
      end
      pend = b_outBuf;
      if (b_done) begin
        if (done_b_q.size() == 0) flag("b_unexpected_done");
        else begin
          d = done_b_q.pop_front();
          check("b_done_cycle", cyc, d.cyc);
          check("b_done_sum", int'(b_outPort), int'(d.sum));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int    k;
    int    k2;
    done_t d;
    reset   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
`ifdef CONTROL_UNIT_ABORT_EN
    a_abort = 1'b0;
    b_abort = 1'b0;
`endif

    // Reset state.
    @(negedge clk);
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_done", int'(a_done), 0);
    check("rst_a_writeEn", int'(a_writeEn), 0);
    check("rst_a_outBuf", int'(a_outBuf), 0);
    check("rst_b_busy", int'(b_busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_a_busy", int'(a_busy), 0);

    // LIMIT=10 run with start pulses while busy that must be ignored.
    start_a(k);
    check("a_busy_after_accept", int'(a_busy), 1);
    wait_cyc(k + 10);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_cyc(k + 30);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_cyc(k + 46);
    check("a_idle_after_run", int'(a_busy), 0);
    check("a_hold_55", int'(a_outPort), 55);
    wait_cyc(k + 48);
    check("a_still_idle", int'(a_busy), 0);
    check("a_hold_55_later", int'(a_outPort), 55);

    // LIMIT=1 run: one ADD, DONE nine edges after acceptance.
    check("b_idle_before_start", int'(b_busy), 0);
    b_start = 1'b1;
    k = cyc + 1;
    sum_b_q.push_back(8'd1);
    d.cyc = k + 9;
    d.sum = 8'd1;
    done_b_q.push_back(d);
    @(negedge clk);
    b_start = 1'b0;
    wait_cyc(k + 11);
    check("b_idle_after_run", int'(b_busy), 0);
    check("b_hold_1", int'(b_outPort), 1);

    // start held high through a whole run: IDLE visited once, then rerun.
    a_start = 1'b1;
    k = cyc + 1;
    k2 = k + 47;
    push_run_a(k);
    push_run_a(k2);
    wait_cyc(k + 46);
    check("held_idle_visit", int'(a_busy), 0);
    @(negedge clk);
    check("held_second_accept", int'(a_busy), 1);
    a_start = 1'b0;
    wait_cyc(k2 + 47);
    check("held_idle_end", int'(a_busy), 0);

    // Reset asserted during the 5th ADD, then a clean rerun.
    start_a(k);
    wait_cyc(k + 27);
    check("rst_mid_in_add", int'(a_outBuf), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", int'(a_busy), 0);
    check("rst_mid_writeEn", int'(a_writeEn), 0);
    sum_a_q.delete();
    done_a_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_a(k);
    wait_cyc(k + 47);
    check("rerun_hold_55", int'(a_outPort), 55);

`ifdef CONTROL_UNIT_ABORT_EN
    // Abort during BUILD_LIM: back to IDLE on the next edge, no done, outPort kept.
    check("abort_idle_before", int'(a_busy), 0);
    a_start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    a_start = 1'b0;
    wait_cyc(k + 6);
    check("abort_in_build_wa", int'(a_wa), 4);
    a_abort = 1'b1;
    #1;
    check("abort_writeEn", int'(a_writeEn), 0);
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_busy", int'(a_busy), 0);
    check("abort_outPort", int'(a_outPort), 55);
    repeat (50) @(negedge clk);
    check("abort_outPort_later", int'(a_outPort), 55);
    check("abort_busy_later", int'(a_busy), 0);
`endif

    repeat (3) @(negedge clk);
    check("a_sum_q_drained", sum_a_q.size(), 0);
    check("a_done_q_drained", done_a_q.size(), 0);
    check("b_sum_q_drained", sum_b_q.size(), 0);
    check("b_done_q_drained", done_b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
